averaging_accumulator: RTL
==========================

AVERAGING_ACCUMULATOR -- requirements
Module: averaging_accumulator

Interface
Parameters (name, default, meaning)
REQ-001 The block SHALL have parameter sample_width, default 12: bit width of sample and average.
REQ-002 The block SHALL have parameter sample_count, default 16: samples per average; power of two, at least 2.
REQ-003 The block SHALL have parameter signed_samples, default 0: 1 means two's-complement sample and average, 0 means unsigned.

Ports (name, direction, width, meaning)
REQ-004 The block SHALL have port clock, input, 1: rising-edge clock.
REQ-005 The block SHALL have port pulsified_reset, input, 1: reset, asynchronous, active-high.
REQ-006 The block SHALL have port clear, input, 1: start a new averaging window.
REQ-007 The block SHALL have port add, input, 1: accumulate sample in this cycle.
REQ-008 The block SHALL have port show, input, 1: level signal; its rising edge publishes the average.
REQ-009 The block SHALL have port sample, input, sample_width: data to be averaged.
REQ-010 The block SHALL have port average, output, sample_width: registered mean of the last complete window.
REQ-011 The block SHALL have port average_valid, output, 1: average belongs to the current window.
REQ-012 The block SHALL have port count_error, output, 1: sticky window-protocol violation.

Function
REQ-013 The accumulator SHALL be sample_width+$clog2(sample_count) bits wide, sign-extended when signed_samples=1, so that sample_count samples never overflow.
REQ-014 The sample counter SHALL be $clog2(sample_count)+1 bits wide and SHALL saturate at sample_count.
REQ-015 clear=1 at a rising clock edge SHALL zero the accumulator, zero the counter, and deassert average_valid and count_error; average SHALL hold its value.
REQ-016 clear SHALL take priority over add and show: when they coincide, sample is discarded and no publish occurs.
REQ-017 add=1 at an edge, with clear=0 and show=0 and counter<sample_count, SHALL add sample to the accumulator and increment the counter; add is level-sampled, one sample per high cycle.
REQ-018 add=1 with counter=sample_count, or with show=1, SHALL be ignored and SHALL set count_error.
REQ-019 A show rising edge SHALL be detected at the first clock edge where show=1 and the internally registered previous show value is 0.
REQ-020 On a show rising edge with counter=sample_count, average SHALL load accumulator>>>$clog2(sample_count) at that same edge, and average_valid SHALL go to 1; average is visible one cycle after show is first sampled high.
REQ-021 The division SHALL truncate toward negative infinity (arithmetic shift); no rounding.
REQ-022 On a show rising edge with counter!=sample_count, average SHALL hold, average_valid SHALL stay 0, and count_error SHALL go to 1.
REQ-023 show held high after its rising edge SHALL cause no further updates.
REQ-024 count_error SHALL remain set until clear or reset.

Reset
REQ-025 pulsified_reset=1 SHALL immediately, independent of clock, force accumulator=0, counter=0, previous show=0, average=0, average_valid=0 and count_error=0.
REQ-026 Reset asserted mid-window SHALL discard the partial sum; normal operation SHALL resume at the first clock edge after release.

Structure
REQ-027 No shared package SHALL be used; accumulator width and shift amount SHALL be local parameters derived with $clog2.
REQ-028 The block SHALL be single-module, with show edge detection done by a local one-bit register; no sub-module.

Verification (sample_width=12, sample_count=16)
REQ-029 Scenario 1: clear, then 16 add pulses with sample=100 -> one cycle after show rises, average=100, average_valid=1, count_error=0.
REQ-030 Scenario 2: samples 0..15, then show -> sum 120, average=7.
REQ-031 Scenario 3: signed_samples=1, 16 samples of -3 -> average=-3 (0xFFD). Then 8 samples of -1 plus 8 samples of 0 -> average=-1.
REQ-032 Scenario 4: only 15 adds, then show -> count_error=1, average_valid=0, average keeps the previous value. Then a 17th add in a full window -> count_error=1.
REQ-033 Scenario 5: reset asserted between clock edges after 8 adds -> all outputs 0 before the next edge. After release, clear plus 16 adds of 50 -> average=50.
REQ-034 Scenario 6: clear and add coincide with sample=4095, then 16 adds of 10 -> average=10, count_error=0.

Source files
------------

// File: rtl/averaging_accumulator.sv
// Windowed averaging accumulator: sums a power-of-two count of samples and
// publishes the floor-mean on the rising edge of show.
module averaging_accumulator #(
  parameter int sample_width   = 12,
  parameter int sample_count   = 16,
  parameter int signed_samples = 0
) (
  input  logic                    clock,
  input  logic                    pulsified_reset,
  input  logic                    clear,
  input  logic                    add,
  input  logic                    show,
  input  logic [sample_width-1:0] sample,
  output logic [sample_width-1:0] average,
  output logic                    average_valid,
  output logic                    count_error
);

  localparam int shift_amount = $clog2(sample_count);
  localparam int acc_width    = sample_width + shift_amount;
  localparam int count_width  = shift_amount + 1;
  localparam logic [count_width-1:0] count_full = count_width'(sample_count);

  logic [acc_width-1:0]   acc;
  logic [count_width-1:0] count;
  logic                   show_prev;

  logic                   window_full;
  logic                   show_rise;
  logic                   add_accept;
  logic                   add_reject;
  logic                   ext_bit;
  logic [acc_width-1:0]   sample_ext;

  // Window protocol: clear opens a window; each cycle with add high takes one
  // sample until sample_count are held; the first cycle show is seen high
  // publishes. add is refused (and flagged) while full or while show is high.
  always_comb begin
    window_full = (count == count_full);
    show_rise   = show & ~show_prev;
    add_accept  = add & ~show & ~window_full;
    add_reject  = add & (show | window_full);
    ext_bit     = (signed_samples != 0) && sample[sample_width-1];
    sample_ext  = {{shift_amount{ext_bit}}, sample};
  end

  always_ff @(posedge clock or posedge pulsified_reset) begin
    if (pulsified_reset) begin
      acc           <= '0;
      count         <= '0;
      show_prev     <= 1'b0;
      average       <= '0;
      average_valid <= 1'b0;
      count_error   <= 1'b0;
    end else begin
      show_prev <= show;
      if (clear) begin
        acc           <= '0;
        count         <= '0;
        average_valid <= 1'b0;
        count_error   <= 1'b0;
      end else begin
        if (add_accept) begin
          acc   <= acc + sample_ext;
          count <= count + count_width'(1);
        end
        if (add_reject) begin
          count_error <= 1'b1;
        end
        // Dropping the low shift_amount bits is the floor division for both
        // signednesses, since the accumulator is already sign-extended.
        if (show_rise) begin
          if (window_full) begin
            average       <= acc[acc_width-1:shift_amount];
            average_valid <= 1'b1;
          end else begin
            count_error   <= 1'b1;
          end
        end
      end
    end
  end

endmodule
